// File: rtl/system_nios2_qsys_0_mul_pkg.sv
// ---------------------------------------------------------------------------
// system_nios2_qsys_0_mul_pkg
//
// Purpose: shared definitions for the Nios II sequential multiply path.
//   - op encodings for MUL / MULXUU / MULXSU / MULXSS
//   - sequencer state enum
//   - operand/accumulator width constants
//   - partial-product table: for issue index k, which operand halves feed
//     the 16x16 multiplier and how far the product is shifted before it
//     is added into the 64-bit accumulator.
// ---------------------------------------------------------------------------
package system_nios2_qsys_0_mul_pkg;

  localparam int MUL_DATA_W = 32;
  localparam int MUL_HALF_W = MUL_DATA_W / 2;
  localparam int MUL_ACC_W  = 2 * MUL_DATA_W;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULXUU = 2'd1,
    OP_MULXSU = 2'd2,
    OP_MULXSS = 2'd3
  } mul_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_CORRECT = 3'd3,
    ST_DONE    = 3'd4
  } mul_state_e;

  // One row of the partial-product table.
  typedef struct packed {
    logic       a_hi;   // take src1[31:16] instead of src1[15:0]
    logic       b_hi;   // take src2[31:16] instead of src2[15:0]
    logic [5:0] shift;  // left shift applied before accumulation
  } pp_entry_t;

  // Issue order: lo*lo, hi*lo, lo*hi, hi*hi. hi*hi comes last so that MUL
  // can stop after three issues when only the low word is needed.
  function automatic pp_entry_t pp_entry(input logic [1:0] k);
    pp_entry_t e;
    e = '{a_hi: 1'b0, b_hi: 1'b0, shift: 6'd0};
    case (k)
      2'd0: e = '{a_hi: 1'b0, b_hi: 1'b0, shift: 6'd0};
      2'd1: e = '{a_hi: 1'b1, b_hi: 1'b0, shift: 6'd16};
      2'd2: e = '{a_hi: 1'b0, b_hi: 1'b1, shift: 6'd16};
      2'd3: e = '{a_hi: 1'b1, b_hi: 1'b1, shift: 6'd32};
      default: e = '{a_hi: 1'b0, b_hi: 1'b0, shift: 6'd0};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/system_nios2_qsys_0_mul_pp16.sv
// ---------------------------------------------------------------------------
// system_nios2_qsys_0_mul_pp16
//
// Purpose: unsigned HALF_W x HALF_W multiplier with a single output
// register (one-cycle latency). Cleared asynchronously by reset.
//
// Ports:
//   clk      in   core clock
//   reset_n  in   asynchronous active-low reset
//   en       in   load enable for the product register
//   a, b     in   HALF_W-bit unsigned operands
//   p        out  2*HALF_W-bit registered product
// ---------------------------------------------------------------------------
module system_nios2_qsys_0_mul_pp16 #(
  parameter int HALF_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [HALF_W-1:0]     a,
  input  logic [HALF_W-1:0]     b,
  output logic [2*HALF_W-1:0]   p
);

  logic [2*HALF_W-1:0] p_d;
  logic [2*HALF_W-1:0] p_q;

  always_comb begin
    p_d = p_q;
    if (en) begin
      p_d = (2*HALF_W)'(a) * (2*HALF_W)'(b);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign p = p_q;

endmodule

// File: rtl/system_nios2_qsys_0_mul_seq.sv
// ---------------------------------------------------------------------------
// system_nios2_qsys_0_mul_seq
//
// Purpose: multi-cycle multiply sequencer for the Nios II multiply path.
// A request is split into 16x16 partial products that are fed one per cycle
// through a registered multiplier and summed into a 64-bit accumulator.
// The high word is then sign-corrected for MULXSU/MULXSS and the selected
// word is held on res_data until the consumer accepts it.
//
// Sequence: IDLE -> ISSUE (N cycles) -> DRAIN -> CORRECT -> DONE -> IDLE
//   N = 3 for MUL when MUL_SKIP_HH=1, otherwise 4.
//
// Ports:
//   clk        in   core clock
//   reset_n    in   asynchronous active-low reset
//   req_valid  in   operand request valid
//   req_ready  out  high in IDLE only
//   req_op     in   0 MUL, 1 MULXUU, 2 MULXSU, 3 MULXSS
//   req_src1   in   operand A
//   req_src2   in   operand B
//   flush      in   kills the in-flight operation (ignored in IDLE)
//   res_valid  out  result valid (DONE state)
//   res_ready  in   consumer accepts result
//   res_data   out  result word, zero when res_valid is low
//
// Optional feature (macro SYSTEM_NIOS2_MUL_ZERO_BYPASS_EN):
//   when defined, a request with a zero operand goes straight to DONE with
//   a zero result and the multiplier is never used.
// ---------------------------------------------------------------------------
module system_nios2_qsys_0_mul_seq
  import system_nios2_qsys_0_mul_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter bit MUL_SKIP_HH = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_src1,
  input  logic [DATA_W-1:0] req_src2,
  input  logic              flush,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data
);

  localparam int HALF_W = DATA_W / 2;
  localparam int ACC_W  = 2 * DATA_W;

  mul_state_e          state_d, state_q;
  logic [1:0]          k_d, k_q;
  mul_op_e             op_d, op_q;
  logic [DATA_W-1:0]   src1_d, src1_q;
  logic [DATA_W-1:0]   src2_d, src2_q;
  logic [ACC_W-1:0]    acc_d, acc_q;
  logic                pp_valid_d, pp_valid_q;
  logic [5:0]          pp_shift_d, pp_shift_q;

  logic [HALF_W-1:0]   mul_a;
  logic [HALF_W-1:0]   mul_b;
  logic [DATA_W-1:0]   mul_p;
  pp_entry_t           cur_pp;
  logic [1:0]          last_k;
  logic [ACC_W-1:0]    addend;
  logic [DATA_W-1:0]   corr_a;
  logic [DATA_W-1:0]   corr_b;
  logic                zero_operand;

  system_nios2_qsys_0_mul_pp16 #(
    .HALF_W (HALF_W)
  ) u_pp16 (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (1'b1),
    .a       (mul_a),
    .b       (mul_b),
    .p       (mul_p)
  );

  // The multiplier output lags the issue by one cycle, so the shift for a
  // partial product travels alongside it in pp_shift_q and is applied when
  // pp_valid_q says the registered product belongs to this operation.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    op_d       = op_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    acc_d      = acc_q;
    pp_valid_d = 1'b0;
    pp_shift_d = pp_shift_q;
    mul_a      = '0;
    mul_b      = '0;

    cur_pp = pp_entry(k_q);
    last_k = ((op_q == OP_MUL) && MUL_SKIP_HH) ? 2'd2 : 2'd3;
    addend = ACC_W'(mul_p) << pp_shift_q;

    // Two's-complement fix-up of the unsigned high word: a negative src1
    // contributes -2^32*src2, a negative src2 contributes -2^32*src1.
    corr_a = ((op_q == OP_MULXSU || op_q == OP_MULXSS) && src1_q[DATA_W-1])
             ? src2_q : '0;
    corr_b = ((op_q == OP_MULXSS) && src2_q[DATA_W-1]) ? src1_q : '0;

    zero_operand = (req_src1 == '0) || (req_src2 == '0);

    if (pp_valid_q) begin
      acc_d = acc_q + addend;
    end

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d   = mul_op_e'(req_op);
          src1_d = req_src1;
          src2_d = req_src2;
          k_d    = 2'd0;
          acc_d  = '0;
          state_d = ST_ISSUE;
`ifdef SYSTEM_NIOS2_MUL_ZERO_BYPASS_EN
          if (zero_operand) begin
            state_d = ST_DONE;
          end
`endif
        end
      end

      ST_ISSUE: begin
        mul_a      = cur_pp.a_hi ? src1_q[DATA_W-1:HALF_W] : src1_q[HALF_W-1:0];
        mul_b      = cur_pp.b_hi ? src2_q[DATA_W-1:HALF_W] : src2_q[HALF_W-1:0];
        pp_valid_d = 1'b1;
        pp_shift_d = cur_pp.shift;
        if (k_q == last_k) begin
          state_d = ST_DRAIN;
        end else begin
          k_d = k_q + 2'd1;
        end
      end

      ST_DRAIN: begin
        state_d = ST_CORRECT;
      end

      ST_CORRECT: begin
        acc_d[ACC_W-1:DATA_W] = acc_q[ACC_W-1:DATA_W] - corr_a - corr_b;
        state_d = ST_DONE;
      end

      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Flush wins over everything else, including the result handshake.
    if (flush && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      acc_d      = '0;
      pp_valid_d = 1'b0;
      k_d        = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      k_q        <= 2'd0;
      op_q       <= OP_MUL;
      src1_q     <= '0;
      src2_q     <= '0;
      acc_q      <= '0;
      pp_valid_q <= 1'b0;
      pp_shift_q <= 6'd0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      op_q       <= op_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      acc_q      <= acc_d;
      pp_valid_q <= pp_valid_d;
      pp_shift_q <= pp_shift_d;
    end
  end

  // Outputs decode directly from state so a reset clears them at once.
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    res_valid = (state_q == ST_DONE);
    res_data  = '0;
    if (state_q == ST_DONE) begin
      res_data = (op_q == OP_MUL) ? acc_q[DATA_W-1:0] : acc_q[ACC_W-1:DATA_W];
    end
  end

endmodule

// File: tb/tb_system_nios2_qsys_0_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_system_nios2_qsys_0_mul_seq
//
// Scoreboard bench for the sequential multiplier. Each accepted request that
// should produce a result pushes its expected word, expected latency and
// acceptance cycle; a monitor pops and compares whenever res_valid appears
// and checks the word stays stable while the consumer stalls.
// ---------------------------------------------------------------------------
module tb_system_nios2_qsys_0_mul_seq;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          acc_cyc;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        flush;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t exp_q[$];
  exp_t cur;
  bit   have_cur = 0;

`ifdef SYSTEM_NIOS2_MUL_ZERO_BYPASS_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 6;
`endif

  system_nios2_qsys_0_mul_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_src1  (req_src1),
    .req_src2  (req_src2),
    .flush     (flush),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Called at #1 after a rising edge. Waits for req_ready, presents one
  // request for a single edge, then scrambles the operand lines so any late
  // sampling by the DUT shows up as a wrong result.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp,
                               input int lat, input bit push);
    int waited = 0;
    exp_t e;
    while (!req_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!req_ready) begin
      checkOutput("req_ready_timeout", {31'd0, req_ready}, 32'd1);
      return;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_src1  = 32'hDEAD_BEEF;
    req_src2  = 32'h5A5A_A5A5;
    req_op    = 2'd3;
    if (push) begin
      e.data    = exp;
      e.lat     = lat;
      e.acc_cyc = cyc;
      exp_q.push_back(e);
    end
    checkOutput("req_ready_busy", {31'd0, req_ready}, 32'd0);
  endtask

  task automatic waitIdle();
    bit idle = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !res_valid && !have_cur) begin
        idle = 1;
        break;
      end
    end
    if (!idle) checkOutput("drain_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: first valid cycle pops and checks data and latency; later
  // valid cycles of the same result check that the word is held.
  always @(negedge clk) begin
    if (!reset_n) begin
      have_cur = 0;
    end else if (res_valid) begin
      if (!have_cur) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_result", res_data, 32'hXXXX_XXXX);
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1;
          checkOutput("res_data", res_data, cur.data);
          checkOutput("latency", 32'(cyc - cur.acc_cyc), 32'(cur.lat));
        end
      end else begin
        checkOutput("res_hold", res_data, cur.data);
      end
      if (res_ready) have_cur = 0;
    end else begin
      have_cur = 0;
    end
  end

  initial begin
    int waited;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'd0;
    req_src1  = 32'd0;
    req_src2  = 32'd0;
    flush     = 1'b0;
    res_ready = 1'b1;
    #12;
    checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("reset_res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("reset_res_data", res_data, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] basic operations");
    applyStimulus(2'd0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 5, 1);
    waitIdle();
    applyStimulus(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 6, 1);
    waitIdle();
    applyStimulus(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6, 1);
    waitIdle();
    applyStimulus(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 6, 1);
    waitIdle();
    applyStimulus(2'd3, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 6, 1);
    waitIdle();
    applyStimulus(2'd2, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 6, 1);
    waitIdle();

    $display("[TB] backpressure");
    res_ready = 1'b0;
    applyStimulus(2'd0, 32'd7, 32'd6, 32'd42, 5, 1);
    waited = 0;
    while (!res_valid && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("bp_res_valid_seen", {31'd0, res_valid}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("bp_still_valid", {31'd0, res_valid}, 32'd1);
    res_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("hs_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("hs_res_valid", {31'd0, res_valid}, 32'd0);
    applyStimulus(2'd0, 32'd3, 32'd5, 32'd15, 5, 1);
    waitIdle();

    $display("[TB] flush during issue");
    applyStimulus(2'd0, 32'h0000_1234, 32'h0000_5678, 32'd0, 5, 0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("flush_res_valid", {31'd0, res_valid}, 32'd0);
    repeat (8) @(posedge clk);
    #1;
    applyStimulus(2'd0, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 5, 1);
    waitIdle();

    $display("[TB] reset during correct");
    applyStimulus(2'd0, 32'h0001_0001, 32'h0001_0001, 32'd0, 5, 0);
    repeat (4) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("rst_mid_res_data", res_data, 32'd0);
    checkOutput("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    $display("[TB] zero operand");
    applyStimulus(2'd3, 32'd0, 32'h1234_5678, 32'd0, ZERO_LAT, 1);
    waitIdle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/system_nios2_qsys_0_mul_seq.md
Name: system_nios2_qsys_0_mul_seq

Overview:
- Multi-cycle multiply sequencer for the Nios II A-stage multiply path, sitting directly upstream of the writeback mux.
- Accepts two 32-bit operands plus an opcode over a valid/ready handshake.
- Computes the product with a single registered 16x16 unsigned partial-product multiplier (one-cycle latency) and a 64-bit accumulator.
- Returns the low word (MUL) or the sign-corrected high word (MULXUU/MULXSU/MULXSS).

Parameters:
- DATA_W, 32, operand/result width; only 32 is supported, HALF_W = DATA_W/2 is derived internally.
- MUL_SKIP_HH, 1, when 1 the MUL op skips the hi*hi partial product (3 issues instead of 4).

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  operand request valid
- req_ready  out  1  sequencer idle, can accept a request
- req_op  in  2  operation: 0 MUL, 1 MULXUU, 2 MULXSU, 3 MULXSS
- req_src1  in  32  operand A (signed for SU/SS)
- req_src2  in  32  operand B (signed for SS)
- flush  in  1  synchronous kill of the in-flight operation
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- res_data  out  32  result word

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset_n` is asynchronous and active-low.
- Reset values: req_ready=1, res_valid=0, res_data=0. Accumulator, multiplier register and state (IDLE) are cleared asynchronously.
- States: IDLE, ISSUE, DRAIN, CORRECT, DONE.
- IDLE:
  - req_ready=1.
  - req_valid at edge E0 captures op/src1/src2 and moves to ISSUE with k=0.
- ISSUE:
  - Cycle k drives partial product k into the multiplier.
  - Order: k0 lo*lo (shift 0), k1 hi*lo (shift 16), k2 lo*hi (shift 16), k3 hi*hi (shift 32).
  - N = 3 for MUL when MUL_SKIP_HH=1, else N = 4.
  - After N cycles, move to DRAIN.
- Accumulation:
  - The product registered at the end of issue cycle k is added, shifted, into the 64-bit accumulator on the following edge.
  - Additions wrap modulo 2^64.
- DRAIN: one cycle to absorb the last product.
- CORRECT: applies the high-word correction modulo 2^32.
  - high -= (op in {SU,SS} & src1[31]) ? src2 : 0
  - high -= (op==SS & src2[31]) ? src1 : 0
  - For MUL and MULXUU the correction is zero, but the state is still executed.
- DONE:
  - res_valid=1.
  - res_data = acc[31:0] for MUL, acc[63:32] otherwise.
  - res_data and res_valid are held stable until res_ready.
- Latency: res_valid rises after edge E(N+2), i.e. 5 edges for MUL and 6 edges for MULX*.
- Result handshake:
  - res_valid & res_ready moves to IDLE at that edge.
  - req_ready=1 in the next cycle; no overlap of requests.
- Flush:
  - flush in any non-IDLE state (including DONE): next edge goes to IDLE, res_valid=0, accumulator cleared.
  - flush in IDLE is ignored.
  - flush has priority over res_ready.
- Reset mid-operation: immediate return to reset values. No partial result is ever presented.
- req_valid while not in IDLE: ignored (req_ready=0); operands are not sampled.

Optional Feature:
- Macro: SYSTEM_NIOS2_MUL_ZERO_BYPASS_EN.
- Defined: if src1==0 or src2==0 at acceptance, go IDLE -> DONE in 1 edge with res_data=0 (all ops); no multiplier activity.
- Undefined: zero operands take the full sequence; latency is always as above.

Decomposition:
- Package system_nios2_qsys_0_mul_pkg:
  - op encodings (MUL/MULXUU/MULXSU/MULXSS)
  - state enum
  - DATA_W/HALF_W constants
  - partial-product index/shift table
- Sub-module system_nios2_qsys_0_mul_pp16:
  - 16x16 unsigned multiplier with one output register.
  - Asynchronous clear on ~reset_n, enable tied high.

Test Plan:
- MUL 0x00010003 * 0x00020005 -> res_data=0x000B000F, res_valid after exactly 5 edges from acceptance, req_ready=0 throughout.
- MULXUU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE after 6 edges. MULXSU same operands -> 0xFFFFFFFF. MULXSS same operands -> 0x00000000.
- MULXSS 0x80000000 * 0x00000002 -> 0xFFFFFFFF. MULXSU 0x80000000 * 0x80000000 -> 0xC0000000.
- Backpressure: MUL 7*6 with res_ready=0 for 3 cycles -> res_data=42 held stable; handshake, then req_ready=1 next cycle; a back-to-back MUL 3*5 -> 15.
- flush in ISSUE k=1 -> IDLE next edge, res_valid never asserts; next MUL 0x0000FFFF*0x0000FFFF -> 0xFFFE0001. reset_n pulsed low in CORRECT -> res_valid/res_data=0 immediately, req_ready=1.
- With SYSTEM_NIOS2_MUL_ZERO_BYPASS_EN: MULXSS 0 * 0x12345678 -> res_data=0, res_valid after 1 edge. Without the macro: same result after 6 edges.
